vexriscv_dbus_axi_bridge: RTL and testbench
===========================================

// Module: vexriscv_dbus_axi_bridge
// PURPOSE
//  Parametrised bridge from the VexRiscv cached dBus (cmd/rsp) to one AXI4 master port.
//  Handles read and write bursts, beat counting, AXI responses and address translation, and
//  decodes the "done" mailbox write locally. Sits between the VexRiscv core and m00_axi.
//  Replaces the ad-hoc combinational dBus glue inside the kernel top-level.
// PARAMETERS
//  ADDR_WIDTH   64            AXI address width (>=32)
//  DATA_WIDTH   32            AXI/dBus data width; 32 or 64
//  MAX_BEATS    8             largest burst accepted; larger size -> error response
//  DONE_ADDR    32'hFFFFFFF0  untranslated write address that raises done_pulse
// PORTS
//  ap_clk           in   1               clock
//  areset           in   1               synchronous, active-high reset
//  abs_address      in   32              translation threshold
//  base_offset      in   ADDR_WIDTH      offset added to low addresses
//  cmd_valid/ready  in/out 1             dBus command handshake
//  cmd_wr,cmd_last  in   1               write flag; CPU last-beat flag
//  cmd_address      in   32              byte address
//  cmd_data,cmd_mask in  DATA_WIDTH,/8   write beat data and byte strobes
//  cmd_size         in   3               log2 bytes of the transfer
//  rsp_valid,rsp_last,rsp_error out 1    response beat
//  rsp_data         out  DATA_WIDTH      read data
//  done_pulse       out  1               one-cycle pulse on a DONE_ADDR write
//  protocol_err     out  1               sticky: CPU last disagrees with beat count
//  m_axi_aw*/w*/b*/ar*/r*  AXI4 master   valid/ready/addr/len/size/burst/data/strb/last/resp
// BEHAVIOUR
//  Reset: FSM=IDLE; every valid output, done_pulse, protocol_err and beat_cnt = 0; bready=rready=0.
//   areset wins over any same-cycle handshake. Reset mid-burst abandons the burst; system
//   asserts areset only while AXI is quiescent.
//  Translate: a = zext(cmd_address); out = (cmd_address > abs_address) ? a : a+base_offset,
//   mod 2^ADDR_WIDTH. DONE_ADDR compares the untranslated address.
//  Beats: B = max(1, 2^cmd_size / (DATA_WIDTH/8)); axlen = B-1; axsize = log2(DATA_WIDTH/8);
//   axburst = INCR. B > MAX_BEATS -> error path, no AXI traffic.
//  FSM (one transaction outstanding): IDLE, AR, R, AW, W, B, ERR, DONE.
//  IDLE, cmd_valid && !wr: cmd_ready=1 for one cycle, latch addr/len, go AR (or ERR).
//  AR: arvalid=1 from the next cycle until arready; go R. arvalid never drops before arready.
//  R: rready=1. rsp_valid=rvalid, rsp_data=rdata, rsp_last=rlast, rsp_error=rresp[1].
//   Go IDLE on rvalid&&rlast. Read latency from cmd acceptance to arvalid = 1 cycle.
//  IDLE, cmd_valid && wr && addr==DONE_ADDR: accept the beat, done_pulse=1 next cycle, go DONE.
//   DONE: rsp_valid=1, rsp_last=1, rsp_error=0 for one cycle, then IDLE.
//  IDLE, cmd_valid && wr (other address): cmd_ready=0; latch addr/len; go AW (or ERR).
//   AW: awvalid=1 until awready; go W.
//  W: wvalid=cmd_valid; wdata/wstrb from cmd; wlast=(beat_cnt==len); cmd_ready=wready.
//   beat_cnt increments on wvalid&&wready. On the final beat go B and clear beat_cnt.
//   cmd_last!=wlast on any accepted beat sets protocol_err (sticky until reset).
//  B: bready=1. On bvalid: rsp_valid=1, rsp_last=1, rsp_error=bresp[1] for one cycle; go IDLE.
//  ERR: consume B command beats (write) or none (read). Emit B rsp beats with rsp_error=1
//   (read) or one (write), then IDLE.
//  cmd_ready=0 in AR, R, AW, B, DONE and ERR-rsp. wready ignored outside W.
//  Counters are width $clog2(MAX_BEATS)+1; they never wrap because legal len < MAX_BEATS.
// STRUCTURE
//  Package vexriscv_axi_pkg: state enum, AXI_BURST_INCR, AXI_RESP_{OKAY,SLVERR,DECERR},
//   function beats_from_size(size, bytes_per_beat).
//  Sub-module vexriscv_addr_xlate: combinational translate, axlen and oversize flag.
//   Instantiated once; the FSM, counters and registers stay in this module.
// TESTING
//  1 read 0x100, size=2, abs=0x8000_0000, base=0x1_0000_0000 -> araddr=0x1_0000_0100, arlen=0,
//    one rsp beat carrying rdata, last=1.
//  2 read 0x9000_0000, size=5, DW=32 -> araddr unchanged, arlen=7, 8 rsp beats, last on 8th.
//  3 write burst of 8 beats with awready delayed 3 cycles -> no wvalid before the AW handshake,
//    wlast on beat 8; bresp=SLVERR -> rsp_error=1.
//  4 write to 0xFFFFFFF0 -> no AXI activity, done_pulse exactly 1 cycle, then one rsp beat.
//  5 read size=7, MAX_BEATS=8, DW=32 -> no arvalid, 32 rsp beats with error=1;
//    write burst with cmd_last early on beat 3 -> protocol_err=1 and stays 1.
//  6 areset asserted in the W state after beat 4 -> next cycle IDLE, all valids 0;
//    a fresh read then completes normally.

Source files
------------

// File: rtl/vexriscv_axi_pkg.sv
// Shared types and helpers for the VexRiscv dBus to AXI4 bridge.
package vexriscv_axi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_AR   = 3'd1,
    ST_R    = 3'd2,
    ST_AW   = 3'd3,
    ST_W    = 3'd4,
    ST_B    = 3'd5,
    ST_ERR  = 3'd6,
    ST_DONE = 3'd7
  } state_e;

  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;
  localparam int         BEAT_W          = 8;

  // Sub-beat transfers still occupy one full bus beat.
  function automatic logic [BEAT_W-1:0] beats_from_size(input logic [2:0] size,
                                                        input logic [BEAT_W-1:0] bytes_per_beat);
    logic [BEAT_W-1:0] bytes;
    logic [BEAT_W-1:0] beats;
    bytes = 8'd1 << size;
    beats = bytes / bytes_per_beat;
    return (beats == 8'd0) ? 8'd1 : beats;
  endfunction

endpackage

// File: rtl/vexriscv_addr_xlate.sv
// Combinational address translation and burst length decode for a dBus command.
module vexriscv_addr_xlate #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BEATS  = 8
) (
  input  logic [31:0]           cmd_address,
  input  logic [31:0]           abs_address,
  input  logic [ADDR_WIDTH-1:0] base_offset,
  input  logic [2:0]            cmd_size,
  output logic [ADDR_WIDTH-1:0] axi_addr,
  output logic [7:0]            axlen,
  output logic                  oversize
);
  import vexriscv_axi_pkg::*;

  localparam logic [BEAT_W-1:0] BYTES_PER_BEAT = BEAT_W'(DATA_WIDTH / 8);

  logic [ADDR_WIDTH-1:0] addr_ext;
  logic [BEAT_W-1:0]     beats;

  // Addresses above the threshold are absolute; lower ones are relocated by base_offset.
  assign addr_ext = ADDR_WIDTH'(cmd_address);
  assign axi_addr = (cmd_address > abs_address) ? addr_ext : addr_ext + base_offset;
  assign beats    = beats_from_size(cmd_size, BYTES_PER_BEAT);
  assign axlen    = beats - 8'd1;
  assign oversize = (beats > BEAT_W'(MAX_BEATS));

endmodule

// File: rtl/vexriscv_dbus_axi_bridge.sv
// VexRiscv cached dBus to AXI4 master bridge, one transaction outstanding,
// with a local "done" mailbox decode and an error path for oversize bursts.
module vexriscv_dbus_axi_bridge #(
  parameter int          ADDR_WIDTH = 64,
  parameter int          DATA_WIDTH = 32,
  parameter int          MAX_BEATS  = 8,
  parameter logic [31:0] DONE_ADDR  = 32'hFFFF_FFF0
) (
  input  logic                    ap_clk,
  input  logic                    areset,
  input  logic [31:0]             abs_address,
  input  logic [ADDR_WIDTH-1:0]   base_offset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_wr,
  input  logic                    cmd_last,
  input  logic [31:0]             cmd_address,
  input  logic [DATA_WIDTH-1:0]   cmd_data,
  input  logic [DATA_WIDTH/8-1:0] cmd_mask,
  input  logic [2:0]              cmd_size,
  output logic                    rsp_valid,
  output logic                    rsp_last,
  output logic                    rsp_error,
  output logic [DATA_WIDTH-1:0]   rsp_data,
  output logic                    done_pulse,
  output logic                    protocol_err,
  output logic                    m_axi_awvalid,
  input  logic                    m_axi_awready,
  output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [7:0]              m_axi_awlen,
  output logic [2:0]              m_axi_awsize,
  output logic [1:0]              m_axi_awburst,
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,
  output logic [DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                    m_axi_wlast,
  input  logic                    m_axi_bvalid,
  output logic                    m_axi_bready,
  input  logic [1:0]              m_axi_bresp,
  output logic                    m_axi_arvalid,
  input  logic                    m_axi_arready,
  output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic [7:0]              m_axi_arlen,
  output logic [2:0]              m_axi_arsize,
  output logic [1:0]              m_axi_arburst,
  input  logic                    m_axi_rvalid,
  output logic                    m_axi_rready,
  input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]              m_axi_rresp,
  input  logic                    m_axi_rlast
);
  import vexriscv_axi_pkg::*;

  localparam int         CNT_W  = $clog2(MAX_BEATS) + 1;
  localparam logic [2:0] AXSIZE = 3'($clog2(DATA_WIDTH / 8));

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]            len_q, len_d;
  logic [CNT_W-1:0]      beat_cnt_q, beat_cnt_d;
  logic [7:0]            err_cnt_q, err_cnt_d;
  logic                  err_rsp_q, err_rsp_d;
  logic                  done_pulse_q, done_pulse_d;
  logic                  protocol_err_q, protocol_err_d;

  logic [ADDR_WIDTH-1:0] x_addr;
  logic [7:0]            x_len;
  logic                  x_oversize;
  logic                  wlast_s;
  logic                  unused_resp_lsbs;

  vexriscv_addr_xlate #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .MAX_BEATS  (MAX_BEATS)
  ) u_xlate (
    .cmd_address (cmd_address),
    .abs_address (abs_address),
    .base_offset (base_offset),
    .cmd_size    (cmd_size),
    .axi_addr    (x_addr),
    .axlen       (x_len),
    .oversize    (x_oversize)
  );

  assign m_axi_awaddr     = addr_q;
  assign m_axi_araddr     = addr_q;
  assign m_axi_awlen      = len_q;
  assign m_axi_arlen      = len_q;
  assign m_axi_awsize     = AXSIZE;
  assign m_axi_arsize     = AXSIZE;
  assign m_axi_awburst    = AXI_BURST_INCR;
  assign m_axi_arburst    = AXI_BURST_INCR;
  assign m_axi_wdata      = cmd_data;
  assign m_axi_wstrb      = cmd_mask;
  assign rsp_data         = m_axi_rdata;
  assign done_pulse       = done_pulse_q;
  assign protocol_err     = protocol_err_q;
  assign wlast_s          = (8'(beat_cnt_q) == len_q);
  assign unused_resp_lsbs = m_axi_rresp[0] ^ m_axi_bresp[0];

  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    len_d          = len_q;
    beat_cnt_d     = beat_cnt_q;
    err_cnt_d      = err_cnt_q;
    err_rsp_d      = err_rsp_q;
    done_pulse_d   = 1'b0;
    protocol_err_d = protocol_err_q;
    cmd_ready      = 1'b0;
    rsp_valid      = 1'b0;
    rsp_last       = 1'b0;
    rsp_error      = 1'b0;
    m_axi_awvalid  = 1'b0;
    m_axi_wvalid   = 1'b0;
    m_axi_wlast    = 1'b0;
    m_axi_bready   = 1'b0;
    m_axi_arvalid  = 1'b0;
    m_axi_rready   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && !cmd_wr) begin
          cmd_ready = 1'b1;
          addr_d    = x_addr;
          len_d     = x_len;
          err_cnt_d = 8'd0;
          err_rsp_d = 1'b1;
          state_d   = x_oversize ? ST_ERR : ST_AR;
        end else if (cmd_valid && (cmd_address == DONE_ADDR)) begin
          cmd_ready    = 1'b1;
          done_pulse_d = 1'b1;
          state_d      = ST_DONE;
        end else if (cmd_valid) begin
          // Write beats stay on the dBus until the W phase consumes them.
          addr_d     = x_addr;
          len_d      = x_len;
          beat_cnt_d = {CNT_W{1'b0}};
          err_cnt_d  = 8'd0;
          err_rsp_d  = 1'b0;
          state_d    = x_oversize ? ST_ERR : ST_AW;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_AR: begin
        m_axi_arvalid = 1'b1;
        state_d       = m_axi_arready ? ST_R : ST_AR;
      end
      ST_R: begin
        m_axi_rready = 1'b1;
        rsp_valid    = m_axi_rvalid;
        rsp_last     = m_axi_rlast;
        rsp_error    = m_axi_rresp[1];
        state_d      = (m_axi_rvalid && m_axi_rlast) ? ST_IDLE : ST_R;
      end
      ST_AW: begin
        m_axi_awvalid = 1'b1;
        state_d       = m_axi_awready ? ST_W : ST_AW;
      end
      ST_W: begin
        m_axi_wvalid = cmd_valid;
        m_axi_wlast  = wlast_s;
        cmd_ready    = m_axi_wready;
        if (cmd_valid && m_axi_wready) begin
          protocol_err_d = protocol_err_q | (cmd_last != wlast_s);
          beat_cnt_d     = wlast_s ? {CNT_W{1'b0}} : beat_cnt_q + CNT_W'(1'b1);
          state_d        = wlast_s ? ST_B : ST_W;
        end else begin
          state_d = ST_W;
        end
      end
      ST_B: begin
        m_axi_bready = 1'b1;
        rsp_valid    = m_axi_bvalid;
        rsp_last     = m_axi_bvalid;
        rsp_error    = m_axi_bvalid & m_axi_bresp[1];
        state_d      = m_axi_bvalid ? ST_IDLE : ST_B;
      end
      ST_ERR: begin
        if (!err_rsp_q) begin
          // Oversize write: swallow every CPU beat, then answer with a single error beat.
          cmd_ready = 1'b1;
          if (cmd_valid && (err_cnt_q == len_q)) begin
            err_rsp_d = 1'b1;
          end else if (cmd_valid) begin
            err_cnt_d = err_cnt_q + 8'd1;
          end else begin
            err_cnt_d = err_cnt_q;
          end
        end else begin
          rsp_valid = 1'b1;
          rsp_error = 1'b1;
          rsp_last  = (err_cnt_q == len_q);
          if (err_cnt_q == len_q) begin
            err_cnt_d = 8'd0;
            err_rsp_d = 1'b0;
            state_d   = ST_IDLE;
          end else begin
            err_cnt_d = err_cnt_q + 8'd1;
          end
        end
      end
      ST_DONE: begin
        rsp_valid = 1'b1;
        rsp_last  = 1'b1;
        state_d   = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge ap_clk) begin
    if (areset) begin
      state_q        <= ST_IDLE;
      addr_q         <= {ADDR_WIDTH{1'b0}};
      len_q          <= 8'd0;
      beat_cnt_q     <= {CNT_W{1'b0}};
      err_cnt_q      <= 8'd0;
      err_rsp_q      <= 1'b0;
      done_pulse_q   <= 1'b0;
      protocol_err_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      addr_q         <= addr_d;
      len_q          <= len_d;
      beat_cnt_q     <= beat_cnt_d;
      err_cnt_q      <= err_cnt_d;
      err_rsp_q      <= err_rsp_d;
      done_pulse_q   <= done_pulse_d;
      protocol_err_q <= protocol_err_d;
    end
  end

endmodule

// File: tb/tb_vexriscv_dbus_axi_bridge.sv
// Directed self-checking bench for vexriscv_dbus_axi_bridge (default parameters).
module tb_vexriscv_dbus_axi_bridge;

  logic        ap_clk = 1'b0;
  logic        areset;
  logic [31:0] abs_address;
  logic [63:0] base_offset;
  logic        cmd_valid, cmd_ready, cmd_wr, cmd_last;
  logic [31:0] cmd_address, cmd_data;
  logic [3:0]  cmd_mask;
  logic [2:0]  cmd_size;
  logic        rsp_valid, rsp_last, rsp_error;
  logic [31:0] rsp_data;
  logic        done_pulse, protocol_err;
  logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  logic        arvalid, arready, rvalid, rready, rlast;
  logic [63:0] awaddr, araddr;
  logic [7:0]  awlen, arlen;
  logic [2:0]  awsize, arsize;
  logic [1:0]  awburst, arburst, bresp, rresp;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;

  int checks   = 0;
  int failures = 0;
  int n_rsp, n_err, n_ar, n_done, n_axi;
  logic got_last;
  logic [8:0] act_vec;

  vexriscv_dbus_axi_bridge dut (
    .ap_clk(ap_clk), .areset(areset), .abs_address(abs_address), .base_offset(base_offset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr), .cmd_last(cmd_last),
    .cmd_address(cmd_address), .cmd_data(cmd_data), .cmd_mask(cmd_mask), .cmd_size(cmd_size),
    .rsp_valid(rsp_valid), .rsp_last(rsp_last), .rsp_error(rsp_error), .rsp_data(rsp_data),
    .done_pulse(done_pulse), .protocol_err(protocol_err),
    .m_axi_awvalid(awvalid), .m_axi_awready(awready), .m_axi_awaddr(awaddr),
    .m_axi_awlen(awlen), .m_axi_awsize(awsize), .m_axi_awburst(awburst),
    .m_axi_wvalid(wvalid), .m_axi_wready(wready), .m_axi_wdata(wdata),
    .m_axi_wstrb(wstrb), .m_axi_wlast(wlast),
    .m_axi_bvalid(bvalid), .m_axi_bready(bready), .m_axi_bresp(bresp),
    .m_axi_arvalid(arvalid), .m_axi_arready(arready), .m_axi_araddr(araddr),
    .m_axi_arlen(arlen), .m_axi_arsize(arsize), .m_axi_arburst(arburst),
    .m_axi_rvalid(rvalid), .m_axi_rready(rready), .m_axi_rdata(rdata),
    .m_axi_rresp(rresp), .m_axi_rlast(rlast)
  );

  always #5 ap_clk = ~ap_clk;

  assign act_vec = {arvalid, awvalid, wvalid, bready, rready, rsp_valid, done_pulse,
                    protocol_err, cmd_ready};

  task automatic step();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_cmd(input logic wr, input logic [31:0] addr, input logic [2:0] size);
    cmd_valid = 1'b1; cmd_wr = wr; cmd_address = addr; cmd_size = size;
    cmd_last = 1'b0; cmd_data = 32'h0; cmd_mask = 4'hF;
  endtask

  initial begin
    areset = 1'b1; abs_address = 32'h8000_0000; base_offset = 64'h1_0000_0000;
    cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_last = 1'b0; cmd_address = 32'h0;
    cmd_data = 32'h0; cmd_mask = 4'h0; cmd_size = 3'd0;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
    arready = 1'b0; rvalid = 1'b0; rdata = 32'h0; rresp = 2'b00; rlast = 1'b0;
    repeat (3) step();
    chk("reset_outputs", act_vec, 9'h000);
    areset = 1'b0;
    step();
    chk("idle_outputs", act_vec, 9'h000);

    // 1: single-beat read of a relocated address
    drive_cmd(1'b0, 32'h0000_0100, 3'd2);
    #1 chk("t1_cmd_ready", cmd_ready, 1'b1);
    step(); cmd_valid = 1'b0;
    #1 chk("t1_arvalid", arvalid, 1'b1);
    chk("t1_araddr", araddr, 64'h1_0000_0100);
    chk("t1_arlen", arlen, 8'd0);
    chk("t1_arsize_burst", {arsize, arburst}, {3'd2, 2'b01});
    arready = 1'b1;
    step(); arready = 1'b0;
    rvalid = 1'b1; rdata = 32'hDEAD_BEEF; rlast = 1'b1; rresp = 2'b00;
    #1 chk("t1_rready", rready, 1'b1);
    chk("t1_rsp", {rsp_valid, rsp_last, rsp_error}, 3'b110);
    chk("t1_rsp_data", rsp_data, 32'hDEAD_BEEF);
    step(); rvalid = 1'b0; rlast = 1'b0;
    #1 chk("t1_back_idle", act_vec, 9'h000);

    // 2: 8-beat read of an absolute address, arready held off two cycles
    drive_cmd(1'b0, 32'h9000_0000, 3'd5);
    step(); cmd_valid = 1'b0;
    #1 chk("t2_araddr", araddr, 64'h0000_0000_9000_0000);
    chk("t2_arlen", arlen, 8'd7);
    step();
    chk("t2_arvalid_held", arvalid, 1'b1);
    arready = 1'b1;
    step(); arready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      rvalid = 1'b1; rdata = 32'hA000_0000 + i; rlast = (i == 7);
      #1 chk("t2_rsp_valid", rsp_valid, 1'b1);
      chk("t2_rsp_data", rsp_data, 32'hA000_0000 + i);
      chk("t2_rsp_last", rsp_last, (i == 7));
      step();
    end
    rvalid = 1'b0; rlast = 1'b0;
    #1 chk("t2_back_idle", act_vec, 9'h000);

    // 3: 8-beat write, awready late, one wready stall, SLVERR response
    drive_cmd(1'b1, 32'h0000_0200, 3'd5);
    #1 chk("t3_no_ready_in_idle", cmd_ready, 1'b0);
    step();
    chk("t3_awaddr", awaddr, 64'h1_0000_0200);
    chk("t3_awlen", awlen, 8'd7);
    for (int i = 0; i < 3; i++) begin
      chk("t3_aw_wait", {awvalid, wvalid, cmd_ready}, 3'b100);
      step();
    end
    awready = 1'b1;
    step(); awready = 1'b0;
    wready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i == 3) begin
        wready = 1'b0;
        #1 chk("t3_stall", {wvalid, cmd_ready}, 2'b10);
        step();
        wready = 1'b1;
      end
      cmd_data = 32'h1000 + i; cmd_last = (i == 7);
      #1 chk("t3_wvalid_ready", {wvalid, cmd_ready}, 2'b11);
      chk("t3_wdata", wdata, 32'h1000 + i);
      chk("t3_wlast", wlast, (i == 7));
      step();
    end
    cmd_valid = 1'b0; wready = 1'b0; cmd_last = 1'b0;
    #1 chk("t3_bready", {bready, rsp_valid}, 2'b10);
    bvalid = 1'b1; bresp = 2'b10;
    #1 chk("t3_b_rsp", {rsp_valid, rsp_last, rsp_error}, 3'b111);
    step(); bvalid = 1'b0; bresp = 2'b00;
    #1 chk("t3_back_idle", act_vec, 9'h000);

    // 4: mailbox write
    drive_cmd(1'b1, 32'hFFFF_FFF0, 3'd2);
    #1 chk("t4_cmd_ready", cmd_ready, 1'b1);
    step(); cmd_valid = 1'b0;
    n_done = 0; n_rsp = 0; n_axi = 0;
    for (int c = 0; c < 5; c++) begin
      #1;
      if (done_pulse) n_done++;
      if (rsp_valid && rsp_last && !rsp_error) n_rsp++;
      if (awvalid || wvalid || arvalid) n_axi++;
      step();
    end
    chk("t4_done_cycles", n_done, 1);
    chk("t4_rsp_beats", n_rsp, 1);
    chk("t4_axi_activity", n_axi, 0);

    // 5a: oversize read answered locally with 32 error beats
    drive_cmd(1'b0, 32'h0000_0300, 3'd7);
    #1 chk("t5_cmd_ready", cmd_ready, 1'b1);
    step(); cmd_valid = 1'b0;
    n_rsp = 0; n_err = 0; n_ar = 0; got_last = 1'b0;
    for (int c = 0; c < 40 && !got_last; c++) begin
      #1;
      if (arvalid) n_ar++;
      if (rsp_valid) begin
        n_rsp++;
        if (rsp_error) n_err++;
        if (rsp_last) got_last = 1'b1;
      end
      step();
    end
    chk("t5_err_beats", n_rsp, 32);
    chk("t5_err_flags", n_err, 32);
    chk("t5_no_arvalid", n_ar, 0);
    chk("t5_last_seen", got_last, 1'b1);

    // 5b: 4-beat write with cmd_last raised early on beat 3
    drive_cmd(1'b1, 32'h0000_0500, 3'd4);
    step();
    chk("t5b_awlen", awlen, 8'd3);
    awready = 1'b1;
    step(); awready = 1'b0; wready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cmd_data = 32'h5000 + i; cmd_last = (i == 2);
      step();
      if (i == 1) chk("t5b_perr_clear", protocol_err, 1'b0);
      if (i == 2) chk("t5b_perr_set", protocol_err, 1'b1);
    end
    cmd_valid = 1'b0; wready = 1'b0; cmd_last = 1'b0;
    bvalid = 1'b1; bresp = 2'b00;
    #1 chk("t5b_b_rsp", {rsp_valid, rsp_last, rsp_error}, 3'b110);
    step(); bvalid = 1'b0;
    step();
    chk("t5b_perr_sticky", protocol_err, 1'b1);

    // 6: reset in the middle of a write burst, then a clean read
    drive_cmd(1'b1, 32'h0000_0600, 3'd5);
    step();
    awready = 1'b1;
    step(); awready = 1'b0; wready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cmd_data = 32'h6000 + i;
      step();
    end
    areset = 1'b1;
    step();
    areset = 1'b0; cmd_valid = 1'b0; wready = 1'b0;
    #1 chk("t6_after_reset", act_vec, 9'h000);
    drive_cmd(1'b0, 32'h9000_0040, 3'd2);
    #1 chk("t6_cmd_ready", cmd_ready, 1'b1);
    step(); cmd_valid = 1'b0;
    chk("t6_araddr", araddr, 64'h0000_0000_9000_0040);
    chk("t6_arlen", arlen, 8'd0);
    arready = 1'b1;
    step(); arready = 1'b0;
    rvalid = 1'b1; rdata = 32'h5555_AAAA; rlast = 1'b1;
    #1 chk("t6_rsp", {rsp_valid, rsp_last, rsp_error}, 3'b110);
    chk("t6_rsp_data", rsp_data, 32'h5555_AAAA);
    step(); rvalid = 1'b0; rlast = 1'b0;
    #1 chk("t6_back_idle", act_vec, 9'h000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
